// File: rtl/bwm_mult_arbiter_if.sv
// Request/response bundle for the shared signed 4x4 multiplier.
// master = requesters plus response consumer, slave = arbiter.
interface bwm_mult_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 3
);
    logic [N_REQ-1:0]   req_valid;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [7:0]         rsp_p;
    logic               rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/bwm_mult_arbiter.sv
// Round-robin arbiter sharing one signed Baugh-Wooley 4x4 multiplier among N_REQ clients.
// Two registered stages (operands, product) with valid/ready backpressure.
module bwm_mult_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 3
) (
    input logic               clk,
    input logic               rst_n,
    bwm_mult_arbiter_if.slave bus
);
    logic            s1_valid;
    logic [3:0]      s1_a;
    logic [3:0]      s1_b;
    logic [ID_W-1:0] s1_id;
    logic [ID_W-1:0] rr_ptr;

    logic            rsp_valid;
    logic [7:0]      rsp_p;
    logic [ID_W-1:0] rsp_id;

    logic            s2_free;
    logic            s1_free;
    logic            win_found;
    logic            accept;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] ptr_next;
    logic [3:0]      win_a;
    logic [3:0]      win_b;
    logic [7:0]      product;

    assign s2_free = !rsp_valid || bus.rsp_ready;
    assign s1_free = !s1_valid || s2_free;
    assign accept  = win_found && s1_free;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin : arb
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        winner    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    assign ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_a = bus.req_a[4*i +: 4];
                win_b = bus.req_b[4*i +: 4];
            end
        end
    end

    // Held low during reset so nothing looks accepted while the pipeline is cleared.
    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            bus.req_ready[i] = rst_n && accept && (winner == ID_W'(i));
        end
    end

    // Baugh-Wooley array: sign-row/column cross terms inverted, 2^7 + 2^4 correction.
    always_comb begin : bwm_4bit
        logic pp;
        pp      = 1'b0;
        product = 8'h90;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp = s1_a[i] & s1_b[j];
                if ((i == 3) != (j == 3)) begin
                    pp = ~pp;
                end
                product = product + ({7'b0, pp} << (i + j));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else begin
            if (s2_free) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_p  <= product;
                    rsp_id <= s1_id;
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= win_a;
                s1_b     <= win_b;
                s1_id    <= winner;
                rr_ptr   <= ptr_next;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_p     = rsp_p;
    assign bus.rsp_id    = rsp_id;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req_ready & ~bus.req_valid) == '0);
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !bus.rsp_ready) |=> ($stable(rsp_p) && $stable(rsp_id) && rsp_valid));
endmodule
